prog_loader: RTL

Boot-time program loader for the picoMIPS core. It accepts a byte stream over a valid/ready handshake and assembles the bytes into Isize-bit instructions. It writes those instructions into the writable program memory that the core's PC reads, and holds the core in reset until the image passes its checksum. It sits between an external byte source (UART receiver or test harness) and the program memory write port, alongside the cpu top level.

---
 rtl/loader_pkg.sv | 17 +
 rtl/instr_assembler.sv | 39 +++
 rtl/prog_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the picoMIPS boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Bytes per instruction for a given instruction width.
    function automatic int unsigned bpi_of(input int unsigned isize);
        return isize / 8;
    endfunction

endpackage

// File: rtl/instr_assembler.sv
// Shifts stream bytes (MSB first) into an instruction and flags the byte that completes it.
module instr_assembler
    import loader_pkg::*;
#(
    parameter int unsigned Isize = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic [7:0]       i_byte,
    output logic [Isize-1:0] o_instr,
    output logic             o_last
);

    localparam int unsigned BPI = bpi_of(Isize);
    localparam int unsigned IW  = (BPI > 1) ? $clog2(BPI) : 1;

    logic [Isize-1:0] r_shift;
    logic [IW-1:0]    r_idx;

    // The completing byte is merged combinationally so the write can be registered on its edge.
    assign o_instr = (r_shift << 8) | Isize'(i_byte);
    assign o_last  = (r_idx == IW'(BPI - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= o_instr;
            r_idx   <= o_last ? '0 : r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: parses count/data/check frames, writes program memory, gates the core.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned Psize = 6,
    parameter int unsigned Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             load_req,
    output logic             wr_en,
    output logic [Psize-1:0] wr_addr,
    output logic [Isize-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam int unsigned CW   = Psize + 1;
    localparam int unsigned IMAX = 1 << Psize;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CW-1:0]    r_inum, w_inum_nxt;
    logic [7:0]       r_csum, w_csum_nxt;
    logic             r_wr_en, w_wr_en_nxt;
    logic [Psize-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [Isize-1:0] r_wr_data, w_wr_data_nxt;
    logic             r_cpu_hold, w_cpu_hold_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic             w_accept, w_asm_clr, w_asm_shift, w_last;
    logic [Isize-1:0] w_instr;
    logic [CW-1:0]    w_inum_inc;

    assign in_ready   = ((r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK))
                        && !load_req;
    assign w_accept   = in_valid && in_ready;
    assign w_inum_inc = r_inum + CW'(1);

    instr_assembler #(.Isize(Isize)) u_asm (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_asm_clr),
        .i_shift (w_asm_shift),
        .i_byte  (in_data),
        .o_instr (w_instr),
        .o_last  (w_last)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_inum_nxt     = r_inum;
        w_csum_nxt     = r_csum;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_cpu_hold_nxt = r_cpu_hold;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_asm_clr      = 1'b0;
        w_asm_shift    = 1'b0;

        if (load_req) begin
            w_state_nxt    = S_COUNT;
            w_cpu_hold_nxt = 1'b1;
            w_error_nxt    = 1'b0;
            w_inum_nxt     = '0;
            w_csum_nxt     = '0;
            w_wr_addr_nxt  = '0;
            w_asm_clr      = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                S_COUNT: begin
                    if (32'(in_data) > IMAX) begin
                        w_state_nxt = S_ERR;
                        w_error_nxt = 1'b1;
                    end else begin
                        // A zero count selects the full 2^Psize image.
                        w_cnt_nxt     = (in_data == 8'd0) ? CW'(IMAX) : CW'(in_data);
                        w_inum_nxt    = '0;
                        w_csum_nxt    = in_data;
                        w_wr_addr_nxt = '0;
                        w_asm_clr     = 1'b1;
                        w_state_nxt   = S_DATA;
                    end
                end
                S_DATA: begin
                    w_asm_shift = 1'b1;
                    w_csum_nxt  = r_csum ^ in_data;
                    if (w_last) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_inum[Psize-1:0];
                        w_wr_data_nxt = w_instr;
                        w_inum_nxt    = w_inum_inc;
                        if (w_inum_inc == r_cnt) begin
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (in_data == r_csum) begin
                        w_state_nxt    = S_RUN;
                        w_cpu_hold_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_error_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_COUNT;
            r_cnt      <= '0;
            r_inum     <= '0;
            r_csum     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inum     <= w_inum_nxt;
            r_csum     <= w_csum_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule
